// File: rtl/ofdm_ifft_feeder_if.sv
// Purpose : handshake bundle between the OFDM symbol source, the IFFT frame
//           feeder and the streaming IFFT sink port.
// Signals : din_*  - mapped constellation symbols into the feeder
//           ifft_* - Avalon-ST frame stream out of the feeder (ready latency 0)
// Modports: master - the feeder (sinks symbols, sources the IFFT stream)
//           slave  - its environment (symbol source plus IFFT sink)
interface ofdm_ifft_feeder_if #(
  parameter int unsigned W     = 10,
  parameter int unsigned LOG2N = 4
) ();

  // symbol input stream
  logic           din_valid;
  logic           din_ready;
  logic [W-1:0]   din_real;
  logic [W-1:0]   din_imag;

  // IFFT sink stream plus its constant sideband
  logic           ifft_valid;
  logic           ifft_ready;
  logic [1:0]     ifft_error;
  logic           ifft_sop;
  logic           ifft_eop;
  logic [W-1:0]   ifft_real;
  logic [W-1:0]   ifft_imag;
  logic [LOG2N:0] ifft_fftpts;
  logic           ifft_inverse;

  modport master (
    input  din_valid, din_real, din_imag, ifft_ready,
    output din_ready, ifft_valid, ifft_error, ifft_sop, ifft_eop,
           ifft_real, ifft_imag, ifft_fftpts, ifft_inverse
  );

  modport slave (
    output din_valid, din_real, din_imag, ifft_ready,
    input  din_ready, ifft_valid, ifft_error, ifft_sop, ifft_eop,
           ifft_real, ifft_imag, ifft_fftpts, ifft_inverse
  );

endinterface

// File: rtl/ofdm_ifft_feeder.sv
// Purpose : OFDM transmit frame builder. Places incoming symbols on the data
//           subcarriers of an NFFT-bin frame, inserts DC/guard nulls and two
//           pilots, and emits each frame as one Avalon-ST packet in natural
//           bin order to the streaming IFFT core.
// Ports   : clk          - clock, rising edge
//           reset        - asynchronous active-high reset
//           bus          - master side of ofdm_ifft_feeder_if (din_*, ifft_*)
//           frame_done_o - one-cycle pulse following the eop transfer
module ofdm_ifft_feeder #(
  parameter int unsigned NFFT      = 16,
  parameter int unsigned LOG2N     = 4,
  parameter int unsigned W         = 10,
  parameter int unsigned NGUARD    = 3,
  parameter int unsigned PILOT_P   = 3,
  parameter int unsigned PILOT_N   = 13,
  parameter int unsigned PILOT_AMP = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  ofdm_ifft_feeder_if.master        bus,
  output logic                      frame_done_o
);

  localparam int unsigned G_LO = NFFT/2 - (NGUARD-1)/2;
  localparam int unsigned G_HI = NFFT/2 + (NGUARD-1)/2;

  localparam logic [LOG2N-1:0] K_LAST = LOG2N'(NFFT-1);
  localparam logic [LOG2N-1:0] K_G_LO = LOG2N'(G_LO);
  localparam logic [LOG2N-1:0] K_G_HI = LOG2N'(G_HI);
  localparam logic [LOG2N-1:0] K_P    = LOG2N'(PILOT_P);
  localparam logic [LOG2N-1:0] K_N    = LOG2N'(PILOT_N);
  localparam logic [W-1:0]     PILOT_RE = W'(PILOT_AMP);
  localparam logic [LOG2N:0]   FFTPTS   = (LOG2N+1)'(NFFT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [LOG2N-1:0] k_q, k_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [W-1:0]     re_q, re_d;
  logic [W-1:0]     im_q, im_d;
  logic             done_q, done_d;

  logic             load_en_c;
  logic             last_c;
  logic             is_null_c;
  logic             is_pilot_c;
  logic             adv_c;
  logic             din_ready_c;

  // Output register may take a new bin when empty or being drained this cycle.
  assign load_en_c = !valid_q || bus.ifft_ready;
  assign last_c    = (k_q == K_LAST);

  // Bin class of the bin about to be loaded.
  always_comb begin
    is_null_c  = (k_q == '0) || ((k_q >= K_G_LO) && (k_q <= K_G_HI));
    is_pilot_c = (k_q == K_P) || (k_q == K_N);
  end

  // Next-state and output-stage load logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    valid_d     = valid_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    re_d        = re_q;
    im_d        = im_q;
    done_d      = 1'b0;
    adv_c       = 1'b0;
    din_ready_c = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The idle cycle also loads the bin-0 null, so back-to-back
        // packets are separated by exactly one empty cycle.
        if (bus.din_valid) begin
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          re_d    = '0;
          im_d    = '0;
          k_d     = LOG2N'(1);
          state_d = S_FRAME;
        end
      end

      S_FRAME: begin
        if (load_en_c) begin
          if (is_null_c || is_pilot_c) begin
            re_d  = is_pilot_c ? PILOT_RE : '0;
            im_d  = '0;
            adv_c = 1'b1;
          end else if (bus.din_valid) begin
            din_ready_c = 1'b1;
            re_d        = bus.din_real;
            im_d        = bus.din_imag;
            adv_c       = 1'b1;
          end

          if (adv_c) begin
            valid_d = 1'b1;
            sop_d   = 1'b0;
            eop_d   = last_c;
            k_d     = last_c ? '0 : k_q + LOG2N'(1);
            state_d = last_c ? S_DRAIN : S_FRAME;
          end else begin
            // Starved data bin: bubble inside the packet, k held.
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
          end
        end
      end

      S_DRAIN: begin
        if (valid_q && bus.ifft_ready) begin
          done_d  = 1'b1;
          valid_d = 1'b0;
          sop_d   = 1'b0;
          eop_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        k_d     = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      re_q    <= re_d;
      im_q    <= im_d;
      done_q  <= done_d;
    end
  end

  assign bus.din_ready    = din_ready_c;
  assign bus.ifft_valid   = valid_q;
  assign bus.ifft_sop     = sop_q;
  assign bus.ifft_eop     = eop_q;
  assign bus.ifft_real    = re_q;
  assign bus.ifft_imag    = im_q;
  assign bus.ifft_error   = 2'b00;
  assign bus.ifft_fftpts  = FFTPTS;
  assign bus.ifft_inverse = 1'b1;
  assign frame_done_o     = done_q;

endmodule

// File: tb/tb_ofdm_ifft_feeder.sv
// Purpose : self-checking bench for ofdm_ifft_feeder. Random symbols are fed
//           through directed scenarios; a bin-layout model with symbol queue
//           predicts every output bin, din_ready, ifft_valid and frame_done.
module tb_ofdm_ifft_feeder;

  localparam int unsigned NFFT      = 16;
  localparam int unsigned LOG2N     = 4;
  localparam int unsigned W         = 10;
  localparam int unsigned NGUARD    = 3;
  localparam int unsigned PILOT_P   = 3;
  localparam int unsigned PILOT_N   = 13;
  localparam int unsigned PILOT_AMP = 256;

  logic clk;
  logic reset;
  logic frame_done;

  ofdm_ifft_feeder_if #(.W(W), .LOG2N(LOG2N)) bus ();

  ofdm_ifft_feeder #(
    .NFFT(NFFT), .LOG2N(LOG2N), .W(W), .NGUARD(NGUARD),
    .PILOT_P(PILOT_P), .PILOT_N(PILOT_N), .PILOT_AMP(PILOT_AMP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .frame_done_o (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // N = null, P = pilot, D = data, one character per bin 0..15
  string layout = "NDDPDDDNNNDDDPDD";

  logic [W-1:0]   acc_re[$];
  logic [W-1:0]   acc_im[$];
  logic [W-1:0]   cur_re, cur_im;
  logic [W-1:0]   lat_re, lat_im;
  logic [2*W+2:0] prev_out;
  int  mon_k;
  bit  exp_valid, exp_done, prev_hold, lat_pend;
  int  cyc, frames, dones, acc_cnt, gaps, sop_cyc, eop_cyc, last_gap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_sym();
    cur_re = W'($urandom);
    cur_im = W'($urandom);
  endtask

  task automatic model_reset();
    acc_re.delete();
    acc_im.delete();
    mon_k     = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    prev_hold = 1'b0;
    lat_pend  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_valid",     bus.ifft_valid,   64'd0);
    chk("rst_din_ready", bus.din_ready,    64'd0);
    chk("rst_sop",       bus.ifft_sop,     64'd0);
    chk("rst_eop",       bus.ifft_eop,     64'd0);
    chk("rst_real",      bus.ifft_real,    64'd0);
    chk("rst_imag",      bus.ifft_imag,    64'd0);
    chk("rst_done",      frame_done,       64'd0);
    chk("rst_error",     bus.ifft_error,   64'd0);
    chk("rst_fftpts",    bus.ifft_fftpts,  64'd16);
    chk("rst_inverse",   bus.ifft_inverse, 64'd1);
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance the model.
  task automatic cycle(input bit dv, input bit rdy);
    bit v, xfer, acc, exp_rdy;
    int l;
    byte c;
    logic [W-1:0] er, ei;
    @(negedge clk);
    bus.din_valid  = dv;
    bus.din_real   = cur_re;
    bus.din_imag   = cur_im;
    bus.ifft_ready = rdy;
    #1;
    cyc++;
    v = exp_valid;
    chk("valid", bus.ifft_valid, v);
    chk("frame_done", frame_done, exp_done);
    if (frame_done === 1'b1) dones++;
    if (prev_hold)
      chk("hold", {bus.ifft_valid, bus.ifft_sop, bus.ifft_eop, bus.ifft_real, bus.ifft_imag}, prev_out);
    if (lat_pend)
      chk("latency", {bus.ifft_valid, bus.ifft_real, bus.ifft_imag}, {1'b1, lat_re, lat_im});
    if (!v && mon_k > 0) gaps++;

    exp_done = 1'b0;
    xfer = v && rdy;
    if (xfer) begin
      c  = layout[mon_k];
      er = '0;
      ei = '0;
      if (c == "P") begin
        er = W'(PILOT_AMP);
      end else if (c == "D") begin
        chk("sym_avail", acc_re.size() != 0, 64'd1);
        if (acc_re.size() != 0) begin
          er = acc_re.pop_front();
          ei = acc_im.pop_front();
        end
      end
      chk("bin", {bus.ifft_sop, bus.ifft_eop, bus.ifft_real, bus.ifft_imag},
          {mon_k == 0, mon_k == NFFT-1, er, ei});
      if (mon_k == 0) begin
        sop_cyc  = cyc;
        last_gap = cyc - eop_cyc - 1;
      end
      if (mon_k == NFFT-1) begin
        eop_cyc  = cyc;
        frames++;
        exp_done = 1'b1;
      end
      mon_k++;
    end

    // l = index of the bin the output register may load this cycle
    l = mon_k;
    exp_rdy = dv && !(v && !rdy) && (l > 0) && (l < NFFT) && (layout[l] == "D");
    chk("din_ready", bus.din_ready, exp_rdy);

    acc = dv && (bus.din_ready === 1'b1);
    lat_pend = acc;
    if (acc) begin
      acc_re.push_back(cur_re);
      acc_im.push_back(cur_im);
      lat_re = cur_re;
      lat_im = cur_im;
      acc_cnt++;
      new_sym();
    end

    prev_hold = v && !rdy;
    prev_out  = {bus.ifft_valid, bus.ifft_sop, bus.ifft_eop, bus.ifft_real, bus.ifft_imag};
    if (prev_hold)      exp_valid = 1'b1;
    else if (l >= NFFT) exp_valid = 1'b0;
    else if (l == 0)    exp_valid = dv;
    else                exp_valid = (layout[l] != "D") || dv;
    if (l >= NFFT) mon_k = 0;
  endtask

  initial begin
    int f0, d0, n, base, stall, starve;
    bit r, d;
    reset = 1'b1;
    bus.din_valid  = 1'b0;
    bus.din_real   = '0;
    bus.din_imag   = '0;
    bus.ifft_ready = 1'b0;
    cyc = 0; frames = 0; dones = 0; acc_cnt = 0; gaps = 0;
    sop_cyc = 0; eop_cyc = 0; last_gap = 0;
    new_sym();
    model_reset();

    // Power-on reset values
    #2;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 1'b1);

    // Full rate frame
    f0 = frames; d0 = dones; gaps = 0; n = 0;
    while (frames == f0 && n < 100) begin cycle(1'b1, 1'b1); n++; end
    chk("full_frames", frames - f0, 64'd1);
    chk("full_span", eop_cyc - sop_cyc, 64'd15);
    chk("full_gaps", gaps, 64'd0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("full_pulse", dones - d0, 64'd1);

    // Backpressure for 3 cycles while bin 5 is presented
    f0 = frames; gaps = 0; n = 0; stall = 3;
    while (frames == f0 && n < 100) begin
      r = !(mon_k == 5 && exp_valid && stall > 0);
      if (!r) stall--;
      cycle(1'b1, r);
      n++;
    end
    chk("bp_frames", frames - f0, 64'd1);
    chk("bp_stalls", stall, 64'd0);
    chk("bp_span", eop_cyc - sop_cyc, 64'd18);
    cycle(1'b0, 1'b1);

    // Starvation: din_valid low 4 cycles before the 4th symbol
    f0 = frames; gaps = 0; n = 0; starve = 4; base = acc_cnt;
    while (frames == f0 && n < 100) begin
      d = !((acc_cnt - base) == 3 && starve > 0);
      if (!d) starve--;
      cycle(d, 1'b1);
      n++;
    end
    chk("starve_frames", frames - f0, 64'd1);
    chk("starve_gaps", gaps, 64'd4);
    chk("starve_span", eop_cyc - sop_cyc, 64'd19);
    cycle(1'b0, 1'b1);

    // Asynchronous reset while bin 8 is in flight
    n = 0; f0 = frames;
    while (mon_k != 8 && n < 100) begin cycle(1'b1, 1'b1); n++; end
    chk("rst_reached_bin8", mon_k, 64'd8);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    bus.din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_no_eop", frames - f0, 64'd0);
    f0 = frames; gaps = 0; n = 0; base = acc_cnt;
    while (frames == f0 && n < 100) begin cycle(1'b1, 1'b1); n++; end
    chk("rst_frames", frames - f0, 64'd1);
    chk("rst_syms", acc_cnt - base, 64'd10);
    cycle(1'b0, 1'b1);

    // Back-to-back: 20 symbols, two packets
    f0 = frames; d0 = dones; n = 0; base = acc_cnt;
    while (frames < f0 + 2 && n < 200) begin cycle(1'b1, 1'b1); n++; end
    chk("b2b_frames", frames - f0, 64'd2);
    chk("b2b_syms", acc_cnt - base, 64'd20);
    chk("b2b_gap", last_gap, 64'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("b2b_pulses", dones - d0, 64'd2);

    // Random valid/ready traffic
    f0 = frames; n = 0;
    while (frames < f0 + 6 && n < 3000) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      n++;
    end
    chk("rand_frames", frames - f0, 64'd6);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("leftover_syms", acc_re.size(), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
